// File: rtl/loop_counter_cfg_seq_pkg.sv
// Shared definitions for the LoopCounterConfig configuration sequencer.
// Holds the FSM state encoding, register-map geometry and AXI response codes.
// Imported by the sequencer top and available to any bench or sibling block.
package loop_counter_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        FIN
    } state_e;

    // Four 32-bit configuration registers at consecutive word offsets.
    localparam int REG_COUNT = 4;
    localparam int ADDR_STEP = 4;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/loop_counter_cfg_seq_if.sv
// AXI4-Lite channel bundle between the sequencer (master) and the
// LoopCounterConfig register slave. Widths follow the instantiating block.
// Master drives requests/ready-for-response; slave drives ready/responses.
interface loop_counter_cfg_seq_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/loop_counter_cfg_seq.sv
// Purpose: on start, latch four config words, write them to regs 0x0..0xC, optionally read back and compare.
// Latency: 17 cycles start-to-done against a zero-wait slave (9 without read-back); registered outputs.
// Backpressure: every VALID holds with stable address/data until READY; one outstanding transaction, no timeout.
module loop_counter_cfg_seq
    import loop_counter_cfg_pkg::*;
#(
    parameter int                            C_M_AXI_ADDR_WIDTH = 4,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
    parameter int                            C_VERIFY           = 1
) (
    input  logic                                      ACLK,
    input  logic                                      ARESETN,
    input  logic                                      start,
    input  logic [REG_COUNT*C_M_AXI_DATA_WIDTH-1:0]   cfg_data,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      error,
    output logic [1:0]                                err_index,
    loop_counter_cfg_seq_if.master                    m_axi
);

    localparam int         AW       = C_M_AXI_ADDR_WIDTH;
    localparam int         DW       = C_M_AXI_DATA_WIDTH;
    localparam logic [1:0] LAST_IDX = 2'(REG_COUNT - 1);

    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [DW-1:0] shadow_q [REG_COUNT];
    logic          load_cfg;

    logic awvalid_q, awvalid_d;
    logic wvalid_q,  wvalid_d;
    logic aw_done_q, aw_done_d;
    logic w_done_q,  w_done_d;
    logic bready_q,  bready_d;
    logic arvalid_q, arvalid_d;
    logic rready_q,  rready_d;
    logic busy_q,    busy_d;
    logic done_q,    done_d;
    logic error_q,   error_d;
    logic [1:0] err_index_q, err_index_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [AW-1:0] reg_addr;

    assign aw_hs = awvalid_q & m_axi.awready;
    assign w_hs  = wvalid_q  & m_axi.wready;
    assign b_hs  = bready_q  & m_axi.bvalid;
    assign ar_hs = arvalid_q & m_axi.arready;
    assign r_hs  = rready_q  & m_axi.rvalid;

    // Register offset wraps modulo the address space, as the slave decodes it.
    assign reg_addr = C_BASE_ADDR + AW'(ADDR_STEP * int'(idx_q));

    assign m_axi.awaddr  = reg_addr;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = shadow_q[idx_q];
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = reg_addr;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_index = err_index_q;

    // Next-state and next-output logic; all channel controls are precomputed so outputs leave flops.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        load_cfg    = 1'b0;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        err_index_d = err_index_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    load_cfg    = 1'b1;
                    error_d     = 1'b0;
                    err_index_d = 2'd0;
                    idx_d       = 2'd0;
                    busy_d      = 1'b1;
                    awvalid_d   = 1'b1;
                    wvalid_d    = 1'b1;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    state_d     = WR_REQ;
                end
            end

            WR_REQ: begin
                // AW and W retire independently; move on only when both have.
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q  | w_hs;
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = WR_RESP;
                end
            end

            WR_RESP: begin
                if (b_hs) begin
                    bready_d = 1'b0;
                    if (m_axi.bresp != AXI_RESP_OKAY) begin
                        error_d     = 1'b1;
                        err_index_d = idx_q;
                        done_d      = 1'b1;
                        state_d     = FIN;
                    end else if (idx_q != LAST_IDX) begin
                        idx_d     = idx_q + 2'd1;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else if (C_VERIFY != 0) begin
                        idx_d     = 2'd0;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end else begin
                        done_d  = 1'b1;
                        state_d = FIN;
                    end
                end
            end

            RD_REQ: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end

            RD_RESP: begin
                if (r_hs) begin
                    rready_d = 1'b0;
                    if ((m_axi.rresp != AXI_RESP_OKAY) || (m_axi.rdata != shadow_q[idx_q])) begin
                        error_d     = 1'b1;
                        err_index_d = idx_q;
                        done_d      = 1'b1;
                        state_d     = FIN;
                    end else if (idx_q != LAST_IDX) begin
                        idx_d     = idx_q + 2'd1;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end else begin
                        done_d  = 1'b1;
                        state_d = FIN;
                    end
                end
            end

            FIN: begin
                // done is high this cycle; start seen here is still ignored.
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered-output flops with synchronous active-low reset.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
        end
    end

    // Shadow copy of the configuration set, captured only when a start is accepted.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int i = 0; i < REG_COUNT; i++) shadow_q[i] <= '0;
        end else if (load_cfg) begin
            for (int i = 0; i < REG_COUNT; i++) shadow_q[i] <= cfg_data[i*DW +: DW];
        end
    end

endmodule

// File: tb/tb_loop_counter_cfg_seq.sv
// Bench for loop_counter_cfg_seq: behavioural AXI4-Lite register slave with
// programmable ready delays and fault injection, plus a transaction-level
// expectation of writes, reads, status and start-to-done latency.
module tb_loop_counter_cfg_seq;

    localparam int AW = 4;
    localparam int DW = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] cfg_data;
    logic         busy, done, error;
    logic [1:0]   err_index;

    int errors = 0;
    int checks = 0;

    loop_counter_cfg_seq_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

    loop_counter_cfg_seq #(
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW),
        .C_BASE_ADDR        (4'h0),
        .C_VERIFY           (1)
    ) dut (
        .ACLK      (clk),
        .ARESETN   (rst_n),
        .start     (start),
        .cfg_data  (cfg_data),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_index (err_index),
        .m_axi     (axi)
    );

    initial forever #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- slave model configuration and logs ----------------
    int          aw_dly, w_dly, ar_dly;
    int          fail_mode;   // 0 none, 1 BRESP error, 2 bad RDATA, 3 RRESP error
    int          fail_idx;
    logic [31:0] bad_val;
    logic [31:0] mem [4];
    logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];

    int            aw_cnt, w_cnt, ar_cnt;
    logic          got_aw, got_w, wr_pend, p_rst;
    logic          p_awv, p_awr, p_wv, p_wr, p_br, p_arv, p_arr, p_rr;
    logic [AW-1:0] p_awaddr, p_araddr, cap_addr;
    logic [31:0]   p_wdata, cap_data;

    // Slave acts at 1 time unit after each rising edge: resolve last cycle's handshakes, then drive.
    initial begin
        axi.awready = 0; axi.wready = 0; axi.arready = 0;
        axi.bvalid = 0; axi.bresp = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                axi.awready = 0; axi.wready = 0; axi.arready = 0;
                axi.bvalid = 0; axi.bresp = 0; axi.rvalid = 0; axi.rresp = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                got_aw = 0; got_w = 0; wr_pend = 0; p_rst = 0;
                p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_br = 0;
                p_arv = 0; p_arr = 0; p_rr = 0;
            end else begin
                logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
                int   ri;
                aw_hs = p_rst && p_awv && p_awr;
                w_hs  = p_rst && p_wv && p_wr;
                b_hs  = p_rst && axi.bvalid && p_br;
                ar_hs = p_rst && p_arv && p_arr;
                r_hs  = p_rst && axi.rvalid && p_rr;

                if (aw_hs) begin got_aw = 1; cap_addr = p_awaddr; end
                if (w_hs)  begin got_w = 1;  cap_data = p_wdata;  end
                if (b_hs)  begin axi.bvalid = 0; wr_pend = 0; end
                if (got_aw && got_w) begin
                    got_aw = 0; got_w = 0; wr_pend = 1;
                    wr_addr_q.push_back(32'(cap_addr));
                    wr_data_q.push_back(cap_data);
                    if (fail_mode == 1 && int'(cap_addr[3:2]) == fail_idx) begin
                        axi.bresp = 2'b10;
                    end else begin
                        axi.bresp = 2'b00;
                        mem[cap_addr[3:2]] = cap_data;
                    end
                    axi.bvalid = 1;
                end
                if (r_hs) axi.rvalid = 0;
                if (ar_hs) begin
                    rd_addr_q.push_back(32'(p_araddr));
                    ri = int'(p_araddr[3:2]);
                    axi.rdata = (fail_mode == 2 && ri == fail_idx) ? bad_val : mem[ri];
                    axi.rresp = (fail_mode == 3 && ri == fail_idx) ? 2'b10 : 2'b00;
                    axi.rvalid = 1;
                end

                // Protocol observations on the master side.
                if (p_rst) begin
                    if (p_awv && !p_awr) check_eq("aw_hold", {axi.awvalid, axi.awaddr}, {1'b1, p_awaddr});
                    if (p_wv && !p_wr)   check_eq("w_hold", {axi.wvalid, axi.wdata}, {1'b1, p_wdata});
                    if (p_arv && !p_arr) check_eq("ar_hold", {axi.arvalid, axi.araddr}, {1'b1, p_araddr});
                    if (aw_hs) check_eq("aw_drop", axi.awvalid, 1'b0);
                    if (w_hs)  check_eq("w_drop", axi.wvalid, 1'b0);
                    if (ar_hs) check_eq("ar_drop", axi.arvalid, 1'b0);
                    if (axi.bready && !p_br) check_eq("bready_after_both", wr_pend, 1'b1);
                end

                if (aw_hs) aw_cnt = 0;
                if (axi.awvalid) begin axi.awready = (aw_cnt >= aw_dly); aw_cnt++; end
                else begin axi.awready = 0; aw_cnt = 0; end
                if (w_hs) w_cnt = 0;
                if (axi.wvalid) begin axi.wready = (w_cnt >= w_dly); w_cnt++; end
                else begin axi.wready = 0; w_cnt = 0; end
                if (ar_hs) ar_cnt = 0;
                if (axi.arvalid) begin axi.arready = (ar_cnt >= ar_dly); ar_cnt++; end
                else begin axi.arready = 0; ar_cnt = 0; end

                p_awv = axi.awvalid; p_awr = axi.awready; p_awaddr = axi.awaddr;
                p_wv = axi.wvalid;   p_wr = axi.wready;   p_wdata = axi.wdata;
                p_arv = axi.arvalid; p_arr = axi.arready; p_araddr = axi.araddr;
                p_br = axi.bready;   p_rr = axi.rready;
                p_rst = 1;
            end
        end
    end

    // One full sequence; expectations come from the register-map rules, not from the DUT.
    task automatic run_seq(input string name, input logic [127:0] cfg,
                           input int awd, input int wd, input int ard,
                           input int mode, input int fidx, input logic [31:0] badv,
                           input bit inject);
        int exp_wr, exp_rd, exp_ei, cyc, dcnt;
        bit exp_err, got, injected;
        logic [31:0] word [4];
        for (int i = 0; i < 4; i++) word[i] = cfg[32*i +: 32];

        exp_wr = 4; exp_rd = 4; exp_err = 0; exp_ei = 0;
        if (mode == 1) begin
            exp_wr = fidx + 1; exp_rd = 0; exp_err = 1; exp_ei = fidx;
        end else if (mode == 2 || mode == 3) begin
            for (int i = 3; i >= 0; i--) begin
                if (i == fidx && (mode == 3 || badv != word[i])) begin
                    exp_rd = i + 1; exp_err = 1; exp_ei = i;
                end
            end
        end

        @(negedge clk);
        aw_dly = awd; w_dly = wd; ar_dly = ard;
        fail_mode = mode; fail_idx = fidx; bad_val = badv;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        cfg_data = cfg;
        start = 1;
        cyc = 0; got = 0; dcnt = 0; injected = 0;
        while (!got && cyc < 500) begin
            @(negedge clk);
            start = 0;
            cyc++;
            if (cyc == 1) check_eq({name, "_busy_after_start"}, busy, 1'b1);
            if (done) begin
                got = 1; dcnt++;
            end else if (inject && !injected && axi.rready) begin
                start = 1; injected = 1;
            end
        end
        start = 0;
        check_eq({name, "_done_seen"}, got, 1'b1);
        if (inject) check_eq({name, "_second_start_issued"}, injected, 1'b1);
        if (awd == 0 && wd == 0 && ard == 0)
            check_eq({name, "_latency"}, cyc, 1 + 2*exp_wr + 2*exp_rd);
        check_eq({name, "_error"}, error, exp_err);
        check_eq({name, "_err_index"}, err_index, exp_ei);
        check_eq({name, "_n_writes"}, wr_addr_q.size(), exp_wr);
        check_eq({name, "_n_reads"}, rd_addr_q.size(), exp_rd);
        for (int i = 0; i < exp_wr && i < wr_addr_q.size(); i++) begin
            check_eq({name, "_wr_addr"}, wr_addr_q[i], 32'(4*i));
            check_eq({name, "_wr_data"}, wr_data_q[i], word[i]);
        end
        for (int i = 0; i < exp_rd && i < rd_addr_q.size(); i++)
            check_eq({name, "_rd_addr"}, rd_addr_q[i], 32'(4*i));
        repeat (4) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check_eq({name, "_done_pulses"}, dcnt, 1);
        check_eq({name, "_busy_after"}, busy, 1'b0);
        check_eq({name, "_error_held"}, error, exp_err);
        check_eq({name, "_writes_after"}, wr_addr_q.size(), exp_wr);
    endtask

    initial begin
        logic [127:0] cfg;
        int mode, fidx, n;
        bit found;
        rst_n = 0; start = 0; cfg_data = '0;
        aw_dly = 0; w_dly = 0; ar_dly = 0; fail_mode = 0; fail_idx = 0; bad_val = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_awvalid", axi.awvalid, 1'b0);
        check_eq("rst_wvalid", axi.wvalid, 1'b0);
        check_eq("rst_bready", axi.bready, 1'b0);
        check_eq("rst_arvalid", axi.arvalid, 1'b0);
        check_eq("rst_rready", axi.rready, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_error", error, 1'b0);
        check_eq("rst_err_index", err_index, 2'd0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        run_seq("basic", {32'd4, 32'd3, 32'd2, 32'd1}, 0, 0, 0, 0, 0, 32'h0, 0);
        run_seq("aw_slow", {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 3, 0, 0, 0, 0, 32'h0, 0);
        run_seq("w_slow", {32'hB4, 32'hB3, 32'hB2, 32'hB1}, 0, 2, 1, 0, 0, 32'h0, 0);
        run_seq("bresp_err", {32'hC4, 32'hC3, 32'hC2, 32'hC1}, 0, 0, 0, 1, 2, 32'h0, 0);
        run_seq("rd_corrupt", {32'd4, 32'd3, 32'd2, 32'd1}, 0, 0, 0, 2, 3, 32'hDEADBEEF, 0);
        run_seq("restart_clean", {32'd8, 32'd7, 32'd6, 32'd5}, 0, 0, 0, 0, 0, 32'h0, 0);
        run_seq("start_in_rd", {32'hE4, 32'hE3, 32'hE2, 32'hE1}, 0, 0, 0, 0, 0, 32'h0, 1);

        // Reset asserted while the second write (idx=1) is being issued.
        @(negedge clk);
        fail_mode = 0; aw_dly = 0; w_dly = 0; ar_dly = 0;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        cfg_data = {32'h44, 32'h33, 32'h22, 32'h11};
        start = 1;
        found = 0; n = 0;
        while (!found && n < 50) begin
            @(negedge clk);
            start = 0; n++;
            if (wr_addr_q.size() == 1 && axi.awvalid) found = 1;
        end
        check_eq("rst_mid_reached_idx1", found, 1'b1);
        rst_n = 0;
        @(negedge clk);
        check_eq("rst_mid_outputs",
                 {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, done, error, err_index},
                 9'd0);
        check_eq("rst_mid_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1;
        run_seq("after_rst", {32'h55, 32'h66, 32'h77, 32'h88}, 0, 0, 0, 0, 0, 32'h0, 0);

        for (int k = 0; k < 20; k++) begin
            cfg = {$urandom, $urandom, $urandom, $urandom};
            mode = $urandom_range(0, 3);
            fidx = $urandom_range(0, 3);
            run_seq("rand", cfg, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                    mode, fidx, cfg[32*fidx +: 32] ^ ($urandom | 32'h1),
                    (mode != 1) && ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
